// File: rtl/seg_scan.sv
// Multiplexed 8-digit, 7-segment display scanner.
// Each digit owns one slot of SLOT_CYC cycles. The first BLANK_CYC cycles of
// every slot drive all digits off so the previous digit's pattern does not
// ghost onto the next one. The eight display codes and the point enables are
// captured once per frame, so a frame never mixes old and new values.
module seg_scan #(
    parameter int SLOT_CYC  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic [3:0] bit_7,
    input  logic [3:0] bit_6,
    input  logic [3:0] bit_5,
    input  logic [3:0] bit_4,
    input  logic [3:0] bit_3,
    input  logic [3:0] bit_2,
    input  logic [3:0] bit_1,
    input  logic [3:0] bit_0,
    input  logic [7:0] dp_en,
    output logic [7:0] sel,
    output logic [7:0] seg,
    output logic       frame_start
);

    localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYC - 1);

    logic [CW-1:0] cnt_slot;
    logic [2:0]    idx;
    logic [3:0]    snap_code [8];
    logic [7:0]    snap_dp;
    logic          slot_end;
    logic          capture;
    logic          blank;
    logic [3:0]    cur_code;
    logic [6:0]    cur_seg;

    assign slot_end = (cnt_slot == SLOT_LAST);
    assign capture  = slot_end && (idx == 3'd7);

    // A zero-length blank window needs no comparator at all.
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign blank = 1'b0;
        end else begin : g_blank
            localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);
            assign blank = (cnt_slot < BLANK_LIM);
        end
    endgenerate

    // Active-low segment pattern {g,f,e,d,c,b,a}; 10 and 12-15 are blank, 11 is a dash.
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'h40;
            4'd1:    pat = 7'h79;
            4'd2:    pat = 7'h24;
            4'd3:    pat = 7'h30;
            4'd4:    pat = 7'h19;
            4'd5:    pat = 7'h12;
            4'd6:    pat = 7'h02;
            4'd7:    pat = 7'h78;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h10;
            4'd11:   pat = 7'h3F;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    // Look up the pattern for the digit currently being scanned.
    always_comb begin
        cur_code = snap_code[idx];
        cur_seg  = decode(cur_code);
    end

    // Slot timer and digit index; the index steps on the last cycle of each slot.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            cnt_slot <= '0;
            idx      <= 3'd0;
        end else if (slot_end) begin
            cnt_slot <= '0;
            idx      <= idx + 3'd1;
        end else begin
            cnt_slot <= cnt_slot + CW'(1);
        end
    end

    // Frame snapshot: inputs are only looked at on the final cycle of digit 7.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                snap_code[i] <= 4'd10;
            end
            snap_dp <= 8'h00;
        end else if (capture) begin
            snap_code[0] <= bit_0;
            snap_code[1] <= bit_1;
            snap_code[2] <= bit_2;
            snap_code[3] <= bit_3;
            snap_code[4] <= bit_4;
            snap_code[5] <= bit_5;
            snap_code[6] <= bit_6;
            snap_code[7] <= bit_7;
            snap_dp      <= dp_en;
        end
    end

    // Registered display drive, one cycle behind the (cnt_slot, idx) state.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            sel         <= 8'hFF;
            seg         <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= capture;
            if (blank) begin
                sel <= 8'hFF;
                seg <= 8'hFF;
            end else begin
                sel <= ~(8'h01 << idx);
                seg <= {~snap_dp[idx], cur_seg};
            end
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with SLOT_CYC=8. One instance uses BLANK_CYC=2,
// a second uses BLANK_CYC=0; both share stimulus. k counts clock edges since
// the last reset release (edge 0 is the first one); outputs are sampled 1 ns
// after each edge and reflect slot (k/8)%8, slot cycle k%8.
module tb_seg_scan;

    logic       sclk = 1'b0;
    logic       rst;
    logic [3:0] b [8];
    logic [7:0] dp_en;
    logic [7:0] sel, seg, sel0, seg0;
    logic       frame_start, frame_start0;

    int checks = 0;
    int errors = 0;
    int k;
    int slot;
    int pos;

    logic [7:0] exp_sel;
    logic [7:0] exp_seg;
    logic       exp_fs;

    // Codes 0..7 with point off.
    logic [7:0] digit_seg [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    // Special-code frame: 10, 15, 11, 3, 4, 11, 6 with point, 7.
    logic [7:0] spec_seg  [8] = '{8'hFF, 8'hFF, 8'hBF, 8'hB0, 8'h99, 8'hBF, 8'h02, 8'hF8};

    always #5 sclk = ~sclk;

    seg_scan #(.SLOT_CYC(8), .BLANK_CYC(2)) dut (
        .sclk(sclk), .rst(rst),
        .bit_7(b[7]), .bit_6(b[6]), .bit_5(b[5]), .bit_4(b[4]),
        .bit_3(b[3]), .bit_2(b[2]), .bit_1(b[1]), .bit_0(b[0]),
        .dp_en(dp_en), .sel(sel), .seg(seg), .frame_start(frame_start)
    );

    seg_scan #(.SLOT_CYC(8), .BLANK_CYC(0)) dut0 (
        .sclk(sclk), .rst(rst),
        .bit_7(b[7]), .bit_6(b[6]), .bit_5(b[5]), .bit_4(b[4]),
        .bit_3(b[3]), .bit_2(b[2]), .bit_1(b[1]), .bit_0(b[0]),
        .dp_en(dp_en), .sel(sel0), .seg(seg0), .frame_start(frame_start0)
    );

    task automatic tick();
        @(posedge sclk);
        #1;
        k = k + 1;
        slot = (k / 8) % 8;
        pos  = k % 8;
        exp_sel = (pos < 2) ? 8'hFF : ~(8'h01 << slot);
        exp_fs  = (k % 64 == 63);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) b[i] = 4'(i);
        dp_en = 8'h00;
        repeat (3) begin
            @(posedge sclk);
            #1;
            checks++;
            if (sel !== 8'hFF || seg !== 8'hFF || frame_start !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold sel=%h seg=%h fs=%b need FF FF 0", sel, seg, frame_start);
            end
            checks++;
            if (sel0 !== 8'hFF || seg0 !== 8'hFF || frame_start0 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold_nb sel=%h seg=%h fs=%b need FF FF 0", sel0, seg0, frame_start0);
            end
        end
        rst = 1'b0;
        k = -1;
    endtask

    // Snapshot still holds code 10 everywhere: every cycle is dark.
    task automatic test_first_frame();
        repeat (64) begin
            tick();
            checks++;
            if (sel !== exp_sel || seg !== 8'hFF || frame_start !== exp_fs) begin
                errors++;
                $display("FAIL first_frame k=%0d sel=%h seg=%h fs=%b need %h FF %b",
                         k, sel, seg, frame_start, exp_sel, exp_fs);
            end
        end
    endtask

    // Second frame shows codes 0..7 in order; slot 3 is F7/B0.
    task automatic test_order();
        repeat (64) begin
            tick();
            exp_seg = (pos < 2) ? 8'hFF : digit_seg[slot];
            checks++;
            if (sel !== exp_sel || seg !== exp_seg || frame_start !== exp_fs) begin
                errors++;
                $display("FAIL order k=%0d sel=%h seg=%h fs=%b need %h %h %b",
                         k, sel, seg, frame_start, exp_sel, exp_seg, exp_fs);
            end
        end
    endtask

    task automatic test_special();
        b[5] = 4'd11; b[2] = 4'd11; b[0] = 4'd10; b[1] = 4'd15;
        dp_en = 8'h40;
        // Not yet captured: this frame still shows 0..7.
        repeat (64) begin
            tick();
            exp_seg = (pos < 2) ? 8'hFF : digit_seg[slot];
            checks++;
            if (sel !== exp_sel || seg !== exp_seg || frame_start !== exp_fs) begin
                errors++;
                $display("FAIL special_hold k=%0d sel=%h seg=%h fs=%b need %h %h %b",
                         k, sel, seg, frame_start, exp_sel, exp_seg, exp_fs);
            end
        end
        repeat (64) begin
            tick();
            exp_seg = (pos < 2) ? 8'hFF : spec_seg[slot];
            checks++;
            if (sel !== exp_sel || seg !== exp_seg || frame_start !== exp_fs) begin
                errors++;
                $display("FAIL special k=%0d sel=%h seg=%h fs=%b need %h %h %b",
                         k, sel, seg, frame_start, exp_sel, exp_seg, exp_fs);
            end
        end
    endtask

    task automatic test_tearing();
        for (int i = 0; i < 8; i++) b[i] = 4'd1;
        dp_en = 8'h00;
        repeat (64) begin
            tick();
            checks++;
            if (frame_start !== exp_fs) begin
                errors++;
                $display("FAIL tear_fs k=%0d fs=%b need %b", k, frame_start, exp_fs);
            end
        end
        repeat (64) begin
            tick();
            exp_seg = (pos < 2) ? 8'hFF : 8'hF9;
            checks++;
            if (sel !== exp_sel || seg !== exp_seg) begin
                errors++;
                $display("FAIL tear_old k=%0d sel=%h seg=%h need %h %h", k, sel, seg, exp_sel, exp_seg);
            end
            if (slot == 4 && pos == 4) begin
                for (int i = 0; i < 8; i++) b[i] = 4'd2;
            end
        end
        repeat (64) begin
            tick();
            exp_seg = (pos < 2) ? 8'hFF : 8'hA4;
            checks++;
            if (sel !== exp_sel || seg !== exp_seg) begin
                errors++;
                $display("FAIL tear_new k=%0d sel=%h seg=%h need %h %h", k, sel, seg, exp_sel, exp_seg);
            end
        end
    endtask

    task automatic test_reset_mid();
        while (k < 492) tick();
        checks++;
        if (sel !== 8'hDF || seg !== 8'hA4) begin
            errors++;
            $display("FAIL mid_pre sel=%h seg=%h need DF A4", sel, seg);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (sel !== 8'hFF || seg !== 8'hFF || sel0 !== 8'hFF || seg0 !== 8'hFF) begin
            errors++;
            $display("FAIL mid_async sel=%h seg=%h sel0=%h seg0=%h need all FF", sel, seg, sel0, seg0);
        end
        repeat (3) begin
            @(posedge sclk);
            #1;
            checks++;
            if (sel !== 8'hFF || seg !== 8'hFF || frame_start !== 1'b0) begin
                errors++;
                $display("FAIL mid_hold sel=%h seg=%h fs=%b need FF FF 0", sel, seg, frame_start);
            end
        end
        rst = 1'b0;
        k = -1;
        // Partial frame discarded: scan restarts at digit 0 with a dark snapshot.
        repeat (64) begin
            tick();
            checks++;
            if (sel !== exp_sel || seg !== 8'hFF || frame_start !== exp_fs) begin
                errors++;
                $display("FAIL mid_restart k=%0d sel=%h seg=%h fs=%b need %h FF %b",
                         k, sel, seg, frame_start, exp_sel, exp_fs);
            end
        end
    endtask

    task automatic test_no_blank();
        rst = 1'b1;
        repeat (2) @(posedge sclk);
        #1;
        rst = 1'b0;
        k = -1;
        repeat (72) begin
            tick();
            exp_sel = ~(8'h01 << slot);
            checks++;
            if (sel0 !== exp_sel || $countones(~sel0) != 1 || frame_start0 !== exp_fs) begin
                errors++;
                $display("FAIL no_blank k=%0d sel=%h fs=%b need %h %b", k, sel0, frame_start0, exp_sel, exp_fs);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        k = 0;
        test_reset();
        test_first_frame();
        test_order();
        test_special();
        test_tearing();
        test_reset_mid();
        test_no_blank();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
